// File: rtl/mem_pkg.sv
// Shared types and default widths for the I/D memory arbiter.
package mem_pkg;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_MASK_SIZE  = MEM_DATA_WIDTH / 8;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] wdata;
        logic [MEM_MASK_SIZE-1:0]  mask;
        logic                      we;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_WIDTH-1:0] data;
        logic                      err;
    } mem_rsp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rsp_slot.sv
// One-entry valid/ready response register; loading and draining may coincide.
module rsp_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         rsp_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         free
);

    logic         valid_r;
    logic [W-1:0] data_r;

    // Slot occupancy and payload; payload only changes on a new load.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_r <= 1'b0;
            data_r  <= {W{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (valid_r && rsp_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign free      = !valid_r || rsp_ready;
    assign rsp_valid = valid_r;
    assign rsp_data  = data_r;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared memory between fetch (I) and load/store (D) ports.
// D has priority; a saturating starvation counter forces an I grant.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
    parameter int STARVE_LIMIT = 4,
    localparam int MASK_SIZE   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] i_rsp_data,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_req_we,
    input  logic [MASK_SIZE-1:0]  d_req_mask,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_rsp_valid,
    input  logic                  d_rsp_ready,
    output logic [DATA_WIDTH-1:0] d_rsp_data,
    output logic                  d_rsp_err,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    output logic [MASK_SIZE-1:0]  mem_mask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_read_resp
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       i_free_s, d_free_s;
    logic       i_elig_s, d_elig_s;
    logic       grant_i_s, grant_d_s;
    logic [3:0] starve_cnt_r;
    arb_state_e state_r, state_s;
    mem_req_t   d_req_s;
    mem_rsp_t   d_load_s;
    logic [DATA_WIDTH:0] d_slot_s;

    assign d_req_s = '{addr: d_req_addr, wdata: d_req_wdata, mask: d_req_mask, we: d_req_we};

    assign i_elig_s  = i_req_valid && i_free_s;
    assign d_elig_s  = d_req_valid && d_free_s;
    // Grants are forced low while reset is asserted so nothing reaches memory.
    assign grant_d_s = arst_n && d_elig_s && !((starve_cnt_r == LIMIT) && i_elig_s);
    assign grant_i_s = arst_n && i_elig_s && !grant_d_s;

    assign i_req_ready = grant_i_s;
    assign d_req_ready = grant_d_s;

    // Memory drive for whichever port holds the grant.
    always_comb begin
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        mem_mask     = {MASK_SIZE{1'b0}};
        mem_addr     = {ADDR_WIDTH{1'b0}};
        mem_data_in  = {DATA_WIDTH{1'b0}};
        if (grant_d_s) begin
            mem_write_en = d_req_s.we;
            mem_read_en  = !d_req_s.we;
            mem_mask     = d_req_s.mask;
            mem_addr     = d_req_s.addr;
            mem_data_in  = d_req_s.wdata;
        end else if (grant_i_s) begin
            mem_read_en  = 1'b1;
            mem_addr     = i_req_addr;
        end else begin
            mem_write_en = 1'b0;
        end
    end

    // Store acks carry zero data and never flag an error.
    always_comb begin
        d_load_s.data = {DATA_WIDTH{1'b0}};
        d_load_s.err  = 1'b0;
        if (!d_req_we) begin
            d_load_s.data = mem_data_out;
            d_load_s.err  = !mem_read_resp;
        end else begin
            d_load_s.err  = 1'b0;
        end
    end

    assign d_slot_s = {d_load_s.err, d_load_s.data};

    rsp_slot #(.W(DATA_WIDTH)) u_i_slot (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (grant_i_s),
        .load_data (mem_data_out),
        .rsp_ready (i_rsp_ready),
        .rsp_valid (i_rsp_valid),
        .rsp_data  (i_rsp_data),
        .free      (i_free_s)
    );

    logic [DATA_WIDTH:0] d_rsp_s;

    rsp_slot #(.W(DATA_WIDTH + 1)) u_d_slot (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (grant_d_s),
        .load_data (d_slot_s),
        .rsp_ready (d_rsp_ready),
        .rsp_valid (d_rsp_valid),
        .rsp_data  (d_rsp_s),
        .free      (d_free_s)
    );

    assign d_rsp_err  = d_rsp_s[DATA_WIDTH];
    assign d_rsp_data = d_rsp_s[DATA_WIDTH-1:0];

    // Counts D grants that bypassed a waiting fetch, saturating at the limit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_i_s || !i_req_valid) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_d_s && (starve_cnt_r < LIMIT)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end
    end

    // Last-winner record, kept for debug visibility only.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next last-winner state.
    always_comb begin
        state_s = state_r;
        case ({grant_d_s, grant_i_s})
            2'b10:   state_s = GNT_D;
            2'b01:   state_s = GNT_I;
            default: state_s = IDLE;
        endcase
    end

endmodule
